wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline's write-back stage and a long-latency unit (multi-cycle multiply/divide, late load return). Pipeline write-back has priority. Long-latency results wait in a small FIFO, and a starvation counter can briefly freeze the pipeline to drain that FIFO. The block also answers pending-write queries for the hazard unit, and sits between the write-back stage and the register file.

---
 rtl/wb_port_arbiter_pkg.sv | 22 ++
 rtl/wb_port_arbiter_if.sv | 33 +++
 rtl/wb_result_fifo.sv | 73 +++++++
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// No logic here; constants, state encoding and the write-request record.
// Imported by the interface, the result FIFO and the arbiter top.
package wb_port_arbiter_pkg;

    localparam int DATA_W_DFLT   = 64;
    localparam int REG_W_DFLT    = 5;
    localparam int ZERO_REG_DFLT = 31;

    // NORMAL: pipeline owns the port; DRAIN: one-cycle freeze to flush a FIFO entry
    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } arb_state_t;

    // One register-file write: destination index plus data
    typedef struct packed {
        logic [REG_W_DFLT-1:0]  rd;
        logic [DATA_W_DFLT-1:0] dat;
    } wr_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of write-back, long-latency, register-file and hazard-query signals.
// master = pipeline/unit/hazard side, slave = the arbiter.
// lu_valid/lu_ready is a valid-ready handshake; everything else is per-cycle.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int REG_W  = REG_W_DFLT
);
    logic              wb_valid;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              lu_valid;
    logic [REG_W-1:0]  lu_reg;
    logic [DATA_W-1:0] lu_data;
    logic              lu_ready;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              pipe_stall;
    logic [REG_W-1:0]  q_reg;
    logic              q_hit;

    modport master (
        output wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data, q_reg,
        input  lu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, q_hit
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data, q_reg,
        output lu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, q_hit
    );
endinterface

// File: rtl/wb_result_fifo.sv
// Small FIFO holding long-latency results, with a per-entry register match vector.
// Latency: an entry pushed at edge N is visible at the head in cycle N+1.
// Backpressure: full/empty exported; pushes while full and pops while empty are ignored.
module wb_result_fifo #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [REG_W-1:0]  push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [REG_W-1:0]  head_reg,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    input  logic [REG_W-1:0]  q_reg,
    output logic [DEPTH-1:0]  match
);
    localparam int AW = $clog2(DEPTH);

    logic [REG_W-1:0]  reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Occupancy is tracked per slot, so full/empty fall out of the valid bits
    assign full      = &vld;
    assign empty     = ~|vld;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_reg  = reg_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Pointer and slot-valid bookkeeping; depth is a power of two so pointers wrap freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr      <= rd_ptr + AW'(1);
                vld[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr      <= wr_ptr + AW'(1);
                vld[wr_ptr] <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: a slot is only read once its valid bit is set
    always_ff @(posedge clk) begin
        if (do_push) begin
            reg_mem[wr_ptr]  <= push_reg;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Hazard lookup: which live slots target the queried register
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = vld[i] && (reg_mem[i] == q_reg);
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between write-back and long-latency results.
// Latency: grant in cycle N -> rf_* in N+1; an lu result is written no earlier than N+2.
// Backpressure: lu_ready drops when the result FIFO is full; starvation forces a 1-cycle pipe_stall.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int REG_W      = REG_W_DFLT,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4,
    parameter int ZERO_REG   = ZERO_REG_DFLT
) (
    input logic             clk,
    input logic             rst_n,
    wb_port_arbiter_if.slave bus
);
    localparam int                CNT_W       = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LAST = CNT_W'(STARVE_MAX - 1);
    localparam logic [REG_W-1:0]  ZREG        = REG_W'(ZERO_REG);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [CNT_W-1:0]    starve_cnt;
    logic [CNT_W-1:0]    starve_cnt_nxt;
    logic                wb_live;
    logic                lu_take;
    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;
    logic [REG_W-1:0]    head_reg;
    logic [DATA_W-1:0]   head_data;
    logic [FIFO_DEPTH-1:0] match;
    logic                grant_wb;
    logic                grant_fifo;
    logic                rf_we_q;
    logic [REG_W-1:0]    rf_waddr_q;
    logic [DATA_W-1:0]   rf_wdata_q;

    // Writes to the hard-wired zero register are dropped at the door
    assign wb_live   = bus.wb_valid && (bus.wb_reg != ZREG);
    assign lu_take   = bus.lu_valid && !fifo_full;
    assign fifo_push = lu_take && (bus.lu_reg != ZREG);

    wb_result_fifo #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_reg  (bus.lu_reg),
        .push_data (bus.lu_data),
        .pop       (grant_fifo),
        .head_reg  (head_reg),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .q_reg     (bus.q_reg),
        .match     (match)
    );

    // Grant selection, starvation counting and the NORMAL/DRAIN transition
    always_comb begin
        grant_wb       = 1'b0;
        grant_fifo     = 1'b0;
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        unique case (state)
            ST_NORMAL: begin
                if (wb_live) begin
                    grant_wb = 1'b1;
                end else if (!fifo_empty) begin
                    grant_fifo = 1'b1;
                end
                // Only a queued result losing to write-back counts as starving;
                // the FIFO cannot pop while WB wins, so it is still non-empty at DRAIN entry
                if (wb_live && !fifo_empty) begin
                    if (starve_cnt == STARVE_LAST) begin
                        state_nxt      = ST_DRAIN;
                        starve_cnt_nxt = '0;
                    end else begin
                        starve_cnt_nxt = starve_cnt + CNT_W'(1);
                    end
                end else begin
                    starve_cnt_nxt = '0;
                end
            end
            ST_DRAIN: begin
                // Pipeline is frozen and will re-present its write-back next cycle
                grant_fifo     = !fifo_empty;
                state_nxt      = ST_NORMAL;
                starve_cnt_nxt = '0;
            end
            default: begin
                state_nxt      = ST_NORMAL;
                starve_cnt_nxt = '0;
            end
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Registered write port; address/data hold when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= grant_wb || grant_fifo;
            if (grant_wb) begin
                rf_waddr_q <= bus.wb_reg;
                rf_wdata_q <= bus.wb_data;
            end else if (grant_fifo) begin
                rf_waddr_q <= head_reg;
                rf_wdata_q <= head_data;
            end
        end
    end

    assign bus.lu_ready   = !fifo_full;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.pipe_stall = (state == ST_DRAIN);
    // Pending write = queued entry or the result crossing the handshake this cycle
    assign bus.q_hit      = (bus.q_reg != ZREG) &&
                            ((|match) || (lu_take && (bus.lu_reg == bus.q_reg)));
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic.
// A queue-based reference model tracks pending results, starvation and expected writes.
// Directed checks use hand-derived constants; the random phase compares against the model.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int         FIFO_DEPTH = 2;
    localparam int         STARVE_MAX = 4;
    localparam logic [4:0] ZR         = 5'd31;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(64), .REG_W(5)) ifc ();

    wb_port_arbiter #(
        .DATA_W     (64),
        .REG_W      (5),
        .FIFO_DEPTH (FIFO_DEPTH),
        .STARVE_MAX (STARVE_MAX),
        .ZERO_REG   (31)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    wr_req_t     ref_q[$];
    bit          m_stall;
    int          m_starve;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [63:0] exp_wdata;
    bit          last_acc;

    task automatic model_reset();
        ref_q.delete();
        m_stall   = 1'b0;
        m_starve  = 0;
        exp_we    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        last_acc  = 1'b0;
    endtask

    // Advance one clock: predict from the inputs presented now, then move the model past the edge
    task automatic tick();
        bit          acc, push, wb_ok, grant, do_pop, nxt_stall;
        int          nxt_starve;
        logic [4:0]  g_rd;
        logic [63:0] g_dat;
        wr_req_t     e;
        acc        = ifc.lu_valid && (ref_q.size() < FIFO_DEPTH);
        push       = acc && (ifc.lu_reg != ZR);
        e.rd       = ifc.lu_reg;
        e.dat      = ifc.lu_data;
        wb_ok      = !m_stall && ifc.wb_valid && (ifc.wb_reg != ZR);
        grant      = 1'b0;
        do_pop     = 1'b0;
        nxt_stall  = 1'b0;
        nxt_starve = 0;
        g_rd       = '0;
        g_dat      = '0;
        if (!wb_ok) begin
            if (ref_q.size() > 0) begin
                grant  = 1'b1;
                do_pop = 1'b1;
                g_rd   = ref_q[0].rd;
                g_dat  = ref_q[0].dat;
            end
        end else begin
            grant = 1'b1;
            g_rd  = ifc.wb_reg;
            g_dat = ifc.wb_data;
            if (ref_q.size() > 0) begin
                if (m_starve + 1 >= STARVE_MAX) nxt_stall = 1'b1;
                else                            nxt_starve = m_starve + 1;
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (do_pop) void'(ref_q.pop_front());
            if (push) ref_q.push_back(e);
            exp_we = grant;
            if (grant) begin
                exp_waddr = g_rd;
                exp_wdata = g_dat;
            end
            m_stall  = nxt_stall;
            m_starve = nxt_starve;
            last_acc = acc;
        end
    endtask

    task automatic idle_inputs();
        ifc.wb_valid = 1'b0;
        ifc.wb_reg   = '0;
        ifc.wb_data  = '0;
        ifc.lu_valid = 1'b0;
        ifc.lu_reg   = '0;
        ifc.lu_data  = '0;
        ifc.q_reg    = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        checks++; if (ifc.rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", ifc.rf_we); end
        checks++; if (ifc.rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", ifc.rf_waddr); end
        checks++; if (ifc.rf_wdata !== 64'd0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", ifc.rf_wdata); end
        checks++; if (ifc.pipe_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", ifc.pipe_stall); end
        checks++; if (ifc.lu_ready !== 1'b1) begin failures++; $display("FAIL reset_lu_ready got=%0b exp=1", ifc.lu_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_wb_only();
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = 5'd5;
        ifc.wb_data  = 64'hDEAD;
        tick();
        checks++; if (ifc.rf_we !== 1'b1) begin failures++; $display("FAIL wb_we got=%0b exp=1", ifc.rf_we); end
        checks++; if (ifc.rf_waddr !== 5'd5) begin failures++; $display("FAIL wb_waddr got=%0d exp=5", ifc.rf_waddr); end
        checks++; if (ifc.rf_wdata !== 64'hDEAD) begin failures++; $display("FAIL wb_wdata got=%0h exp=dead", ifc.rf_wdata); end
        ifc.wb_reg  = ZR;
        ifc.wb_data = 64'hBEEF;
        tick();
        checks++; if (ifc.rf_we !== 1'b0) begin failures++; $display("FAIL wb_zero_we got=%0b exp=0", ifc.rf_we); end
        checks++; if (ifc.rf_waddr !== 5'd5) begin failures++; $display("FAIL wb_zero_hold_addr got=%0d exp=5", ifc.rf_waddr); end
        checks++; if (ifc.rf_wdata !== 64'hDEAD) begin failures++; $display("FAIL wb_zero_hold_data got=%0h exp=dead", ifc.rf_wdata); end
        ifc.wb_valid = 1'b0;
    endtask

    task automatic test_idle_port();
        ifc.lu_valid = 1'b1;
        ifc.lu_reg   = 5'd7;
        ifc.lu_data  = 64'h11;
        ifc.q_reg    = 5'd7;
        #1;
        checks++; if (ifc.lu_ready !== 1'b1) begin failures++; $display("FAIL idle_lu_ready got=%0b exp=1", ifc.lu_ready); end
        checks++; if (ifc.q_hit !== 1'b1) begin failures++; $display("FAIL idle_qhit_inflight got=%0b exp=1", ifc.q_hit); end
        tick();
        ifc.lu_valid = 1'b0;
        #1;
        checks++; if (ifc.rf_we !== 1'b0) begin failures++; $display("FAIL idle_early_we got=%0b exp=0", ifc.rf_we); end
        checks++; if (ifc.q_hit !== 1'b1) begin failures++; $display("FAIL idle_qhit_queued got=%0b exp=1", ifc.q_hit); end
        tick();
        checks++; if (ifc.rf_we !== 1'b1) begin failures++; $display("FAIL idle_we got=%0b exp=1", ifc.rf_we); end
        checks++; if (ifc.rf_waddr !== 5'd7) begin failures++; $display("FAIL idle_waddr got=%0d exp=7", ifc.rf_waddr); end
        checks++; if (ifc.rf_wdata !== 64'h11) begin failures++; $display("FAIL idle_wdata got=%0h exp=11", ifc.rf_wdata); end
        checks++; if (ifc.q_hit !== 1'b0) begin failures++; $display("FAIL idle_qhit_after got=%0b exp=0", ifc.q_hit); end
    endtask

    task automatic test_starvation();
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = 5'd4;
        ifc.wb_data  = 64'hA0;
        ifc.lu_valid = 1'b1;
        ifc.lu_reg   = 5'd12;
        ifc.lu_data  = 64'h55;
        tick();
        ifc.lu_valid = 1'b0;
        for (int i = 1; i <= STARVE_MAX; i++) begin
            checks++; if (ifc.pipe_stall !== 1'b0) begin failures++; $display("FAIL starve_early_stall cycle=%0d got=%0b exp=0", i, ifc.pipe_stall); end
            ifc.wb_data = 64'hA0 + 64'(i);
            tick();
        end
        checks++; if (ifc.pipe_stall !== 1'b1) begin failures++; $display("FAIL starve_stall got=%0b exp=1", ifc.pipe_stall); end
        checks++; if (ifc.rf_wdata !== 64'hA4) begin failures++; $display("FAIL starve_last_wb got=%0h exp=a4", ifc.rf_wdata); end
        ifc.wb_data = 64'hA5;
        tick();
        checks++; if (ifc.pipe_stall !== 1'b0) begin failures++; $display("FAIL starve_stall_len got=%0b exp=0", ifc.pipe_stall); end
        checks++; if (ifc.rf_we !== 1'b1 || ifc.rf_waddr !== 5'd12 || ifc.rf_wdata !== 64'h55) begin
            failures++; $display("FAIL starve_drain_write got=%0b/%0d/%0h exp=1/12/55", ifc.rf_we, ifc.rf_waddr, ifc.rf_wdata); end
        tick();
        checks++; if (ifc.rf_we !== 1'b1 || ifc.rf_waddr !== 5'd4 || ifc.rf_wdata !== 64'hA5) begin
            failures++; $display("FAIL starve_held_wb got=%0b/%0d/%0h exp=1/4/a5", ifc.rf_we, ifc.rf_waddr, ifc.rf_wdata); end
        ifc.wb_valid = 1'b0;
    endtask

    task automatic test_full_fifo();
        int         held;
        bit         saw_stall;
        logic [4:0] got[$];
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = 5'd3;
        ifc.wb_data  = 64'h300;
        ifc.lu_valid = 1'b1;
        ifc.lu_reg   = 5'd8;
        ifc.lu_data  = 64'h800;
        #1;
        checks++; if (ifc.lu_ready !== 1'b1) begin failures++; $display("FAIL full_ready0 got=%0b exp=1", ifc.lu_ready); end
        tick();
        ifc.lu_reg  = 5'd9;
        ifc.lu_data = 64'h900;
        #1;
        checks++; if (ifc.lu_ready !== 1'b1) begin failures++; $display("FAIL full_ready1 got=%0b exp=1", ifc.lu_ready); end
        tick();
        ifc.lu_reg  = 5'd10;
        ifc.lu_data = 64'hA00;
        #1;
        checks++; if (ifc.lu_ready !== 1'b0) begin failures++; $display("FAIL full_ready2 got=%0b exp=0", ifc.lu_ready); end
        held      = 0;
        saw_stall = 1'b0;
        while (ref_q.size() >= FIFO_DEPTH && held < 16) begin
            tick();
            held++;
            if (ifc.pipe_stall === 1'b1) saw_stall = 1'b1;
        end
        checks++; if (held != 4) begin failures++; $display("FAIL full_hold_cycles got=%0d exp=4", held); end
        checks++; if (!saw_stall) begin failures++; $display("FAIL full_drain_seen got=0 exp=1"); end
        checks++; if (ifc.lu_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after got=%0b exp=1", ifc.lu_ready); end
        checks++; if (ifc.rf_waddr !== 5'd8) begin failures++; $display("FAIL full_first_drain got=%0d exp=8", ifc.rf_waddr); end
        tick();
        ifc.lu_valid = 1'b0;
        ifc.wb_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ifc.rf_we === 1'b1) got.push_back(ifc.rf_waddr);
            tick();
        end
        checks++; if (got.size() != 3) begin failures++; $display("FAIL full_write_count got=%0d exp=3", got.size()); end
        else begin
            checks++; if (got[0] !== 5'd3 || got[1] !== 5'd9 || got[2] !== 5'd10) begin
                failures++; $display("FAIL full_order got=%0d,%0d,%0d exp=3,9,10", got[0], got[1], got[2]); end
        end
    endtask

    task automatic test_simultaneous();
        ifc.wb_valid = 1'b0;
        ifc.lu_valid = 1'b1;
        ifc.lu_reg   = 5'd14;
        ifc.lu_data  = 64'hE1;
        tick();
        ifc.lu_reg  = 5'd15;
        ifc.lu_data = 64'hF1;
        #1;
        checks++; if (ifc.lu_ready !== 1'b1) begin failures++; $display("FAIL simul_ready got=%0b exp=1", ifc.lu_ready); end
        tick();
        ifc.lu_valid = 1'b0;
        ifc.q_reg    = 5'd15;
        #1;
        checks++; if (ifc.q_hit !== 1'b1) begin failures++; $display("FAIL simul_qhit15 got=%0b exp=1", ifc.q_hit); end
        checks++; if (ifc.lu_ready !== 1'b1) begin failures++; $display("FAIL simul_count got=%0b exp=1", ifc.lu_ready); end
        checks++; if (ifc.rf_waddr !== 5'd14 || ifc.rf_wdata !== 64'hE1) begin
            failures++; $display("FAIL simul_first got=%0d/%0h exp=14/e1", ifc.rf_waddr, ifc.rf_wdata); end
        ifc.q_reg = 5'd14;
        #1;
        checks++; if (ifc.q_hit !== 1'b0) begin failures++; $display("FAIL simul_qhit14 got=%0b exp=0", ifc.q_hit); end
        tick();
        checks++; if (ifc.rf_waddr !== 5'd15 || ifc.rf_wdata !== 64'hF1) begin
            failures++; $display("FAIL simul_second got=%0d/%0h exp=15/f1", ifc.rf_waddr, ifc.rf_wdata); end
    endtask

    task automatic test_reset_mid();
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = 5'd2;
        ifc.wb_data  = 64'h22;
        ifc.lu_valid = 1'b1;
        ifc.lu_reg   = 5'd20;
        ifc.lu_data  = 64'h200;
        tick();
        ifc.lu_reg  = 5'd21;
        ifc.lu_data = 64'h210;
        tick();
        checks++; if (ref_q.size() != 2) begin failures++; $display("FAIL rstmid_setup got=%0d exp=2", ref_q.size()); end
        ifc.wb_valid = 1'b0;
        ifc.lu_valid = 1'b0;
        ifc.q_reg    = 5'd20;
        rst_n        = 1'b0;
        #1;
        checks++; if (ifc.rf_we !== 1'b0 || ifc.rf_waddr !== 5'd0 || ifc.rf_wdata !== 64'd0) begin
            failures++; $display("FAIL rstmid_rf got=%0b/%0d/%0h exp=0/0/0", ifc.rf_we, ifc.rf_waddr, ifc.rf_wdata); end
        checks++; if (ifc.pipe_stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%0b exp=0", ifc.pipe_stall); end
        checks++; if (ifc.lu_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", ifc.lu_ready); end
        checks++; if (ifc.q_hit !== 1'b0) begin failures++; $display("FAIL rstmid_qhit got=%0b exp=0", ifc.q_hit); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ifc.rf_we !== 1'b0) begin failures++; $display("FAIL rstmid_ghost cycle=%0d got=%0b exp=0", i, ifc.rf_we); end
        end
    endtask

    task automatic test_random();
        int rate;
        idle_inputs();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rate = (cyc < 200) ? 85 : 40;
            // A frozen pipeline keeps presenting the same write-back
            if (!m_stall) begin
                ifc.wb_valid = ($urandom_range(0, 99) < rate);
                ifc.wb_reg   = ($urandom_range(0, 9) == 0) ? ZR : 5'($urandom_range(0, 30));
                ifc.wb_data  = {$urandom, $urandom};
            end
            // The unit holds an offered result until it is accepted
            if (!(ifc.lu_valid && !last_acc)) begin
                ifc.lu_valid = ($urandom_range(0, 9) < 5);
                ifc.lu_reg   = ($urandom_range(0, 9) == 0) ? ZR : 5'($urandom_range(0, 30));
                ifc.lu_data  = {$urandom, $urandom};
            end
            if (ref_q.size() > 0 && $urandom_range(0, 1) == 1)
                ifc.q_reg = ref_q[$urandom_range(0, ref_q.size() - 1)].rd;
            else
                ifc.q_reg = 5'($urandom_range(0, 31));
            #1;
            checks++; if (ifc.lu_ready !== (ref_q.size() < FIFO_DEPTH)) begin
                failures++; $display("FAIL rnd_lu_ready cyc=%0d got=%0b exp=%0b", cyc, ifc.lu_ready, ref_q.size() < FIFO_DEPTH); end
            begin
                bit hit;
                hit = ifc.lu_valid && (ref_q.size() < FIFO_DEPTH) && (ifc.lu_reg == ifc.q_reg);
                foreach (ref_q[k]) if (ref_q[k].rd == ifc.q_reg) hit = 1'b1;
                if (ifc.q_reg == ZR) hit = 1'b0;
                checks++; if (ifc.q_hit !== hit) begin
                    failures++; $display("FAIL rnd_qhit cyc=%0d got=%0b exp=%0b", cyc, ifc.q_hit, hit); end
            end
            tick();
            checks++; if (ifc.rf_we !== exp_we) begin
                failures++; $display("FAIL rnd_we cyc=%0d got=%0b exp=%0b", cyc, ifc.rf_we, exp_we); end
            checks++; if (ifc.rf_waddr !== exp_waddr || ifc.rf_wdata !== exp_wdata) begin
                failures++; $display("FAIL rnd_wr cyc=%0d got=%0d/%0h exp=%0d/%0h", cyc, ifc.rf_waddr, ifc.rf_wdata, exp_waddr, exp_wdata); end
            checks++; if (ifc.pipe_stall !== m_stall) begin
                failures++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", cyc, ifc.pipe_stall, m_stall); end
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wb_only();
        test_idle_port();
        test_starvation();
        test_full_fifo();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
